// File: rtl/ctu_clsp_clkgn_nstep_multi.sv
// N-step clock-enable generator: steps selected clock domains by a programmed count of divided cycles.
// Optional CTU_NSTEP_CAPTURE_EN adds capture_l, which freezes stepping domains while low.
module ctu_clsp_clkgn_nstep_multi #(
    parameter int NUM_DOM = 3,
    parameter int CNT_W   = 4,
    parameter int DIV_W   = 14
) (
    input  logic                     clk,
    input  logic                     io_pwron_rst,
    input  logic                     testmode_l,
    input  logic                     nstep_vld,
    input  logic [NUM_DOM-1:0]       nstep_domain,
    input  logic [CNT_W-1:0]         nstep_count,
    input  logic [NUM_DOM*DIV_W-1:0] div_mult,
    input  logic [NUM_DOM-1:0]       force_cken,
`ifdef CTU_NSTEP_CAPTURE_EN
    input  logic                     capture_l,
`endif
    output logic                     nstep_ack,
    output logic                     nstep_err,
    output logic                     nstep_busy,
    output logic                     nstep_done,
    output logic [NUM_DOM-1:0]       nstep_sel,
    output logic [NUM_DOM-1:0]       nstep_cken
);

    typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, DONE = 2'd2} st_e;

    st_e              st_q    [NUM_DOM];
    st_e              st_d    [NUM_DOM];
    logic [DIV_W-1:0] phase_q [NUM_DOM];
    logic [DIV_W-1:0] phase_d [NUM_DOM];
    logic [DIV_W-1:0] div_q   [NUM_DOM];
    logic [DIV_W-1:0] div_d   [NUM_DOM];
    logic [CNT_W:0]   rem_q   [NUM_DOM];
    logic [CNT_W:0]   rem_d   [NUM_DOM];

    logic               ack_q, err_q, busy_q, done_q;
    logic               ack_d, err_d, busy_d, done_d;
    logic [NUM_DOM-1:0] sel_q, cken_q, sel_d, cken_d;
    logic               accept;
    logic               run;

`ifdef CTU_NSTEP_CAPTURE_EN
    assign run = capture_l;
`else
    assign run = 1'b1;
`endif

    // A zero count encodes the full 2**CNT_W steps via the extra MSB
    function automatic logic [CNT_W:0] eff_count(input logic [CNT_W-1:0] cnt);
        return {(cnt == '0), cnt};
    endfunction

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
        return (div == '0) ? DIV_W'(1) : div;
    endfunction

    assign accept = nstep_vld & testmode_l & ~busy_q & (|nstep_domain);

    // State register: control state is reset, per-domain counters are only qualified by STEP
    always_ff @(posedge clk or posedge io_pwron_rst) begin
        if (io_pwron_rst) begin
            for (int d = 0; d < NUM_DOM; d++) st_q[d] <= IDLE;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sel_q  <= '0;
            cken_q <= '0;
        end else begin
            for (int d = 0; d < NUM_DOM; d++) st_q[d] <= st_d[d];
            ack_q  <= ack_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sel_q  <= sel_d;
            cken_q <= cken_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int d = 0; d < NUM_DOM; d++) begin
            phase_q[d] <= phase_d[d];
            rem_q[d]   <= rem_d[d];
            div_q[d]   <= div_d[d];
        end
    end

    // Next-state logic for every domain FSM
    always_comb begin
        for (int d = 0; d < NUM_DOM; d++) begin
            st_d[d]    = st_q[d];
            phase_d[d] = phase_q[d];
            rem_d[d]   = rem_q[d];
            div_d[d]   = div_q[d];
            case (st_q[d])
                IDLE: begin
                    if (accept && nstep_domain[d]) begin
                        st_d[d]    = STEP;
                        phase_d[d] = '0;
                        rem_d[d]   = eff_count(nstep_count);
                        div_d[d]   = eff_div(div_mult[d*DIV_W +: DIV_W]);
                    end
                end
                STEP: begin
                    if (run) begin
                        if (phase_q[d] == div_q[d] - DIV_W'(1)) begin
                            phase_d[d] = '0;
                            rem_d[d]   = rem_q[d] - (CNT_W+1)'(1);
                            if (rem_q[d] == (CNT_W+1)'(1)) st_d[d] = DONE;
                        end else begin
                            phase_d[d] = phase_q[d] + DIV_W'(1);
                        end
                    end
                end
                DONE:    st_d[d] = IDLE;
                default: st_d[d] = IDLE;
            endcase
        end
    end

    // Output decode from next state, so every flag is registered
    always_comb begin
        logic any_done;
        logic any_step;
        any_done = 1'b0;
        any_step = 1'b0;
        sel_d    = '0;
        cken_d   = '0;
        for (int d = 0; d < NUM_DOM; d++) begin
            sel_d[d]  = (st_d[d] != IDLE);
            cken_d[d] = (st_d[d] == STEP) && (phase_d[d] == div_d[d] - DIV_W'(1));
            any_done  = any_done | (st_d[d] == DONE);
            any_step  = any_step | (st_d[d] == STEP);
        end
        done_d = any_done & ~any_step;
        busy_d = |sel_d;
        ack_d  = accept;
        err_d  = nstep_vld & ~accept;
    end

    // force_cken overrides the FSM outputs but must still read as zero while in reset
    assign nstep_ack  = ack_q;
    assign nstep_err  = err_q;
    assign nstep_busy = busy_q;
    assign nstep_done = done_q;
    assign nstep_sel  = (sel_q | force_cken) & ~{NUM_DOM{io_pwron_rst}};
    assign nstep_cken = ((cken_q & {NUM_DOM{run}}) | force_cken) & ~{NUM_DOM{io_pwron_rst}};

endmodule

// File: tb/tb_ctu_clsp_clkgn_nstep_multi.sv
// Bench for ctu_clsp_clkgn_nstep_multi: directed table, hand sequences and random requests vs. a schedule model.
module tb_ctu_clsp_clkgn_nstep_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        testmode_l;
    logic        nstep_vld;
    logic [2:0]  dom;
    logic [3:0]  cnt;
    logic [41:0] divm;
    logic [2:0]  frc;
`ifdef CTU_NSTEP_CAPTURE_EN
    logic        capture_l;
`endif
    logic        ack, err, busy, done;
    logic [2:0]  sel, cken;

    ctu_clsp_clkgn_nstep_multi #(.NUM_DOM(3), .CNT_W(4), .DIV_W(14)) dut (
        .clk          (clk),
        .io_pwron_rst (rst),
        .testmode_l   (testmode_l),
        .nstep_vld    (nstep_vld),
        .nstep_domain (dom),
        .nstep_count  (cnt),
        .div_mult     (divm),
        .force_cken   (frc),
`ifdef CTU_NSTEP_CAPTURE_EN
        .capture_l    (capture_l),
`endif
        .nstep_ack    (ack),
        .nstep_err    (err),
        .nstep_busy   (busy),
        .nstep_done   (done),
        .nstep_sel    (sel),
        .nstep_cken   (cken)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit chk_en = 1'b1;

    // Reference model: a request is a schedule of pulse cycles relative to its accept cycle
    bit m_valid;
    int m_t, m_end, m_ack_cyc, m_err_cyc;
    bit m_act [3];
    int m_n   [3];
    int m_div [3];

    function automatic int effn(input logic [3:0] c);
        return (c == 4'd0) ? 16 : int'(c);
    endfunction

    function automatic int effd(input logic [13:0] d);
        return (d == 14'd0) ? 1 : int'(d);
    endfunction

    task automatic model_clear();
        m_valid   = 1'b0;
        m_ack_cyc = -10;
        m_err_cyc = -10;
    endtask

    function automatic bit model_busy(input int c);
        return m_valid && (c >= m_t + 1) && (c <= m_end);
    endfunction

    task automatic check();
        logic [2:0] e_sel, e_ck;
        logic       e_ack, e_err, e_busy, e_done;
        e_sel = '0;
        e_ck  = '0;
        for (int d = 0; d < 3; d++) begin
            if (m_valid && m_act[d] && cyc >= m_t + 1) begin
                e_sel[d] = (cyc <= m_t + m_n[d] * m_div[d] + 1);
                e_ck[d]  = (cyc <= m_t + m_n[d] * m_div[d]) && (((cyc - m_t) % m_div[d]) == 0);
            end
        end
        e_busy = model_busy(cyc);
        e_done = m_valid && (cyc == m_end);
        e_ack  = (cyc == m_ack_cyc);
        e_err  = (cyc == m_err_cyc);
        e_sel  = e_sel | frc;
        e_ck   = e_ck | frc;
        if (rst) begin
            e_sel = '0; e_ck = '0; e_ack = 0; e_err = 0; e_busy = 0; e_done = 0;
        end
        nvec++;
        if ({ack, err, busy, done, sel, cken} !== {e_ack, e_err, e_busy, e_done, e_sel, e_ck}) begin
            nerr++;
            $display("FAIL cycle%0d outputs: got ack=%b err=%b busy=%b done=%b sel=%b cken=%b, want ack=%b err=%b busy=%b done=%b sel=%b cken=%b",
                     cyc, ack, err, busy, done, sel, cken, e_ack, e_err, e_busy, e_done, e_sel, e_ck);
        end
    endtask

    // Ends the current cycle, updates the model with that cycle's inputs, then checks the new cycle
    task automatic tick();
        int mx;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (nstep_vld) begin
            if (testmode_l && !model_busy(cyc) && dom != 3'b000) begin
                m_valid = 1'b1;
                m_t     = cyc;
                mx      = 0;
                for (int d = 0; d < 3; d++) begin
                    m_act[d] = dom[d];
                    m_n[d]   = effn(cnt);
                    m_div[d] = effd(divm[d*14 +: 14]);
                    if (dom[d] && m_n[d] * m_div[d] > mx) mx = m_n[d] * m_div[d];
                end
                m_end     = m_t + mx + 1;
                m_ack_cyc = cyc + 1;
            end else begin
                m_err_cyc = cyc + 1;
            end
        end
        cyc++;
        #1;
        if (chk_en) check();
    endtask

    task automatic cmp(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    typedef struct {
        logic [2:0]  dom;
        logic [3:0]  cnt;
        logic [13:0] d0, d1, d2;
        logic        tm;
        logic [2:0]  frc;
        logic        exp_ack;
        logic        exp_err;
        int          exp_done;
    } vec_t;

    vec_t vt [8];

    initial begin
        int t0;
        int done_off;
        vt[0] = '{3'b001, 4'd4, 14'd1, 14'd1, 14'd1, 1'b1, 3'b000, 1'b1, 1'b0, 5};
        vt[1] = '{3'b110, 4'd2, 14'd1, 14'd3, 14'd5, 1'b1, 3'b000, 1'b1, 1'b0, 11};
        vt[2] = '{3'b001, 4'd0, 14'd0, 14'd1, 14'd1, 1'b1, 3'b000, 1'b1, 1'b0, 17};
        vt[3] = '{3'b000, 4'd3, 14'd1, 14'd1, 14'd1, 1'b1, 3'b000, 1'b0, 1'b1, 0};
        vt[4] = '{3'b001, 4'd2, 14'd1, 14'd1, 14'd1, 1'b0, 3'b000, 1'b0, 1'b1, 0};
        vt[5] = '{3'b110, 4'd2, 14'd1, 14'd3, 14'd5, 1'b1, 3'b100, 1'b1, 1'b0, 11};
        vt[6] = '{3'b111, 4'd3, 14'd2, 14'd4, 14'd1, 1'b1, 3'b000, 1'b1, 1'b0, 13};
        vt[7] = '{3'b010, 4'd1, 14'd0, 14'd7, 14'd0, 1'b1, 3'b000, 1'b1, 1'b0, 8};

        rst = 1'b1; testmode_l = 1'b1; nstep_vld = 1'b0; dom = '0; cnt = '0; divm = '0; frc = '0;
`ifdef CTU_NSTEP_CAPTURE_EN
        capture_l = 1'b1;
`endif
        model_clear();
        #1;
        check();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Directed table
        for (int i = 0; i < 8; i++) begin
            dom = vt[i].dom; cnt = vt[i].cnt; testmode_l = vt[i].tm; frc = vt[i].frc;
            divm = {vt[i].d2, vt[i].d1, vt[i].d0};
            nstep_vld = 1'b1;
            tick();
            t0 = cyc - 1;
            nstep_vld = 1'b0;
            testmode_l = 1'b1;
            cmp($sformatf("vec%0d ack", i), int'(ack), int'(vt[i].exp_ack));
            cmp($sformatf("vec%0d err", i), int'(err), int'(vt[i].exp_err));
            done_off = 0;
            for (int k = 0; k < 30; k++) begin
                if (done && done_off == 0) done_off = cyc - t0;
                tick();
            end
            cmp($sformatf("vec%0d done offset", i), done_off, vt[i].exp_done);
            frc = '0;
        end

        // Rejection while busy and during the DONE cycle
        dom = 3'b001; cnt = 4'd4; divm = {14'd1, 14'd1, 14'd1};
        nstep_vld = 1'b1;
        tick();
        tick();
        nstep_vld = 1'b0;
        cmp("busy reject ack", int'(ack), 0);
        cmp("busy reject err", int'(err), 1);
        repeat (3) tick();
        cmp("done cycle", int'(done), 1);
        nstep_vld = 1'b1;
        tick();
        nstep_vld = 1'b0;
        cmp("done-cycle reject err", int'(err), 1);
        repeat (5) tick();

        // Forced domain plus reset mid-step: everything drops at once and no done follows
        dom = 3'b110; cnt = 4'd2; divm = {14'd5, 14'd3, 14'd1}; frc = 3'b100;
        nstep_vld = 1'b1;
        tick();
        nstep_vld = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        cmp("async reset outputs", int'({ack, err, busy, done, sel, cken}), 0);
        repeat (2) tick();
        rst = 1'b0;
        done_off = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done) done_off = 1;
        end
        cmp("no done after reset", done_off, 0);
        frc = '0;

        // Random requests with changing ratios and occasional force
        for (int i = 0; i < 400; i++) begin
            nstep_vld  = ($urandom_range(0, 2) == 0);
            dom        = 3'($urandom_range(0, 7));
            cnt        = 4'($urandom_range(0, 15));
            divm       = {14'($urandom_range(0, 5)), 14'($urandom_range(0, 5)), 14'($urandom_range(0, 5))};
            testmode_l = ($urandom_range(0, 9) != 0);
            frc        = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tick();
        end
        nstep_vld = 1'b0; frc = '0; testmode_l = 1'b1;
        repeat (100) tick();

`ifdef CTU_NSTEP_CAPTURE_EN
        begin
            logic [8:0] exp_ck;
            chk_en = 1'b0;
            exp_ck = 9'b001110001;
            dom = 3'b001; cnt = 4'd4; divm = {14'd1, 14'd1, 14'd1};
            nstep_vld = 1'b1;
            tick();
            nstep_vld = 1'b0;
            for (int k = 1; k <= 9; k++) begin
                capture_l = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
                #1;
                cmp($sformatf("capture cken t+%0d", k), int'(cken[0]), int'(exp_ck[k-1]));
                cmp($sformatf("capture done t+%0d", k), int'(done), (k == 8) ? 1 : 0);
                tick();
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
